// File: rtl/ov7670_pkg.sv
// Shared types and defaults for the OV7670 stream generator: FSM phases, RGB565 pixel
// and the 8-bar test pattern palette.
package ov7670_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBP,
        ACTIVE,
        VFP
    } state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam int DEF_H_ACTIVE    = 320;
    localparam int DEF_V_ACTIVE    = 240;
    localparam int DEF_H_BLANK     = 144;
    localparam int DEF_VSYNC_LINES = 3;
    localparam int DEF_V_BP        = 17;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_ADDR_W      = 17;

    // White, yellow, cyan, green, magenta, red, blue, black.
    localparam rgb565_t BAR_COLORS [8] = '{
        rgb565_t'(16'hFFFF), rgb565_t'(16'hFFE0), rgb565_t'(16'h07FF), rgb565_t'(16'h07E0),
        rgb565_t'(16'hF81F), rgb565_t'(16'hF800), rgb565_t'(16'h001F), rgb565_t'(16'h0000)
    };

endpackage

// File: rtl/ov7670_color_bar.sv
// Combinational 8-bar colour pattern: pixel column index to RGB565 colour.
// Only instantiated when OV7670_STREAM_GEN_PATTERN_EN is defined.
module ov7670_color_bar
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int IDX_W    = 9
) (
    input  logic [IDX_W-1:0] pixel,
    output rgb565_t          color
);

    logic [2:0] bar;

    always_comb begin
        bar   = 3'((32'(pixel) * 32'd8) / 32'(H_ACTIVE));
        color = BAR_COLORS[bar];
    end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670-style pixel bus generator: frame-buffer reads to vsync/href/byte-serial d.
// Optional internal colour-bar source selected by pattern_sel under OV7670_STREAM_GEN_PATTERN_EN.
module ov7670_stream_gen
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BP        = DEF_V_BP,
    parameter int V_FP        = DEF_V_FP,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              enable,
`ifdef OV7670_STREAM_GEN_PATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              vsync,
    output logic              href,
    output logic [7:0]        d,
    output logic              frame_start,
    output logic              busy
);

    localparam int L        = 2 * H_ACTIVE + H_BLANK;
    localparam int COL_W    = $clog2(L);
    localparam int LM_A     = (VSYNC_LINES > V_BP) ? VSYNC_LINES : V_BP;
    localparam int LM_B     = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
    localparam int LINE_W   = $clog2(((LM_A > LM_B) ? LM_A : LM_B) + 1);

    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(L - 1);
    localparam logic [COL_W-1:0] COL_PREFETCH = COL_W'(L - 2);
    localparam logic [COL_W-1:0] COL_HREF_END = COL_W'(2 * H_ACTIVE);
    localparam logic [COL_W-1:0] COL_READ_END = COL_W'(2 * H_ACTIVE - 2);

    localparam state_t FIRST_PHASE = (VSYNC_LINES > 0) ? VSYNC : ((V_BP > 0) ? VBP : ACTIVE);
    localparam state_t LAST_PHASE  = (V_FP > 0) ? VFP : ACTIVE;

    function automatic logic [LINE_W-1:0] phase_last_line(state_t s);
        case (s)
            VSYNC:   return LINE_W'(VSYNC_LINES - 1);
            VBP:     return LINE_W'(V_BP - 1);
            ACTIVE:  return LINE_W'(V_ACTIVE - 1);
            VFP:     return LINE_W'(V_FP - 1);
            default: return '0;
        endcase
    endfunction

    function automatic state_t phase_after(state_t s);
        case (s)
            VSYNC:   return (V_BP > 0) ? VBP : ACTIVE;
            VBP:     return ACTIVE;
            ACTIVE:  return VFP;
            default: return IDLE;
        endcase
    endfunction

    state_t            state, state_n;
    logic [COL_W-1:0]  col, col_n;
    logic [LINE_W-1:0] line, line_n;
    logic              start, frame_end;
    logic              in_line_n, prefetch_n, rd_n;
    logic [15:0]       pix;
    logic [7:0]        d_n, lo_hold, lo_n;
    logic [ADDR_W-1:0] pix_cnt;

`ifdef OV7670_STREAM_GEN_PATTERN_EN
    logic    pat_mode, pat_n;
    rgb565_t bar_color;

    ov7670_color_bar #(
        .H_ACTIVE (H_ACTIVE),
        .IDX_W    (COL_W - 1)
    ) u_color_bar (
        .pixel (col_n[COL_W-1:1]),
        .color (bar_color)
    );
`endif

    // Frame position of the next cycle; all outputs are registered from it.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_n   = state;
        col_n     = col;
        line_n    = line;
        start     = 1'b0;
        frame_end = (state == LAST_PHASE) && (line == phase_last_line(state)) && (col == COL_LAST);
        if (state == IDLE) begin
            start = enable;
        end else if (col == COL_LAST) begin
            col_n = '0;
            if (frame_end) begin
                state_n = IDLE;
                line_n  = '0;
                start   = enable;
            end else if (line == phase_last_line(state)) begin
                state_n = phase_after(state);
                line_n  = '0;
            end else begin
                line_n = line + 1'b1;
            end
        end else begin
            col_n = col + 1'b1;
        end
        if (start) begin
            state_n = FIRST_PHASE;
            col_n   = '0;
            line_n  = '0;
        end
    end

    // Reads run two cycles ahead of the high byte; pixel 0 is fetched in the previous line's blanking.
    always_comb begin
        in_line_n  = (state_n == ACTIVE) && (col_n < COL_HREF_END);
        prefetch_n = (col_n == COL_PREFETCH) &&
                     (((state_n == ACTIVE) && (line_n != LINE_W'(V_ACTIVE - 1))) ||
                      ((state_n == VBP) && (line_n == LINE_W'(V_BP - 1))) ||
                      ((V_BP == 0) && (state_n == VSYNC) && (line_n == LINE_W'(VSYNC_LINES - 1))));
        rd_n       = prefetch_n || (in_line_n && !col_n[0] && (col_n < COL_READ_END));
        pix        = rd_data;
`ifdef OV7670_STREAM_GEN_PATTERN_EN
        pat_n = start ? pattern_sel : pat_mode;
        if (pat_n) begin
            rd_n = 1'b0;
            pix  = bar_color;
        end
`endif
        d_n  = '0;
        lo_n = lo_hold;
        if (in_line_n) begin
            if (!col_n[0]) begin
                d_n  = pix[15:8];
                lo_n = pix[7:0];
            end else begin
                d_n = lo_hold;
            end
        end
    end

    always_ff @(posedge pclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state       <= IDLE;
            col         <= '0;
            line        <= '0;
            lo_hold     <= '0;
            pix_cnt     <= '0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            vsync       <= 1'b0;
            href        <= 1'b0;
            d           <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
`ifdef OV7670_STREAM_GEN_PATTERN_EN
            pat_mode    <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            col         <= col_n;
            line        <= line_n;
            lo_hold     <= lo_n;
            rd_en       <= rd_n;
            vsync       <= (state_n == VSYNC);
            href        <= in_line_n;
            d           <= d_n;
            frame_start <= start;
            busy        <= (state_n != IDLE);
            if (start || (state_n == IDLE)) begin
                pix_cnt <= '0;
                rd_addr <= '0;
            end else if (rd_n) begin
                rd_addr <= pix_cnt;
                pix_cnt <= pix_cnt + 1'b1;
            end
`ifdef OV7670_STREAM_GEN_PATTERN_EN
            pat_mode    <= pat_n;
`endif
        end
    end

endmodule
